// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate extender.
// Format select encoding and instruction width.
package imm_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    IMM_U    = 3'd0,
    IMM_I    = 3'd1,
    IMM_J    = 3'd2,
    IMM_S    = 3'd3,
    IMM_B    = 3'd4,
    IMM_Z    = 3'd5,
    IMM_SH   = 3'd6,
    IMM_RSVD = 3'd7
  } imm_src_t;

  // Control half of a buffered entry; the data half is sized by the top's parameters.
  typedef struct packed {
    logic vld;
    logic err;
  } entry_flags_t;

endpackage

// File: rtl/imm_format.sv
// Combinational RV32I immediate formatter: instruction word + format select -> XLEN immediate.
// Latency 0; no flow control.
module imm_format
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instruct,
  input  imm_src_t           imm_src,
  output logic [XLEN-1:0]    extended,
  output logic               err
);

  logic [31:0] raw;
  logic        unused_opcode;

  assign unused_opcode = ^instruct[6:0];

  // raw is a 32-bit signed value; zero-extended forms keep bit 31 clear so a
  // single sign extension below covers every format.
  always_comb begin
    raw = '0;
    err = 1'b0;
    case (imm_src)
      IMM_U:  raw = {instruct[31:12], 12'b0};
      IMM_I:  raw = {{20{instruct[31]}}, instruct[31:20]};
      IMM_J:  raw = {{11{instruct[31]}}, instruct[31], instruct[19:12],
                     instruct[20], instruct[30:21], 1'b0};
      IMM_S:  raw = {{20{instruct[31]}}, instruct[31:25], instruct[11:7]};
      IMM_B:  raw = {{19{instruct[31]}}, instruct[31], instruct[7],
                     instruct[30:25], instruct[11:8], 1'b0};
      IMM_Z:  raw = {27'b0, instruct[19:15]};
      IMM_SH: raw = (XLEN == 32) ? {27'b0, instruct[24:20]} : {26'b0, instruct[25:20]};
      default: err = 1'b1;
    endcase
  end

  assign extended = XLEN'($signed(raw));

endmodule

// File: rtl/imm_extender_pipe.sv
// Registered immediate extender with a 2-entry skid buffer and sideband tag.
// Latency 1 cycle; in_ready depends only on skid occupancy, never on out_ready.
module imm_extender_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instruct,
  input  logic [2:0]         immSrc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    extended,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_extender_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  ext;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  entry_t nxt, r0, r1;
  logic   r0_vld, r1_vld;
  logic   accept, consume;

  imm_format #(.XLEN(XLEN)) u_fmt (
    .instruct (instruct),
    .imm_src  (imm_src_t'(immSrc)),
    .extended (nxt.ext),
    .err      (nxt.err)
  );
  assign nxt.tag = in_tag;

  assign in_ready = ~r1_vld & ~rst;
  assign accept   = in_valid & in_ready;
  assign consume  = r0_vld & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_vld <= 1'b0;
      r1_vld <= 1'b0;
      r0     <= '0;
      r1     <= '0;
    end else if (flush) begin
      r0_vld <= 1'b0;
      r1_vld <= 1'b0;
    end else if (consume) begin
      if (r1_vld) begin
        r0     <= r1;
        r1_vld <= accept;
        if (accept) r1 <= nxt;
      end else begin
        r0_vld <= accept;
        if (accept) r0 <= nxt;
      end
    end else if (!r0_vld) begin
      r0_vld <= accept;
      if (accept) r0 <= nxt;
    end else if (accept) begin
      r1_vld <= 1'b1;
      r1     <= nxt;
    end
  end

  // Gate with rst so outputs read zero for the whole reset window, not just after the edge.
  assign out_valid = r0_vld & ~rst;
  assign extended  = rst ? '0 : r0.ext;
  assign out_tag   = rst ? '0 : r0.tag;
  assign out_err   = r0.err & ~rst;

endmodule

// File: doc/imm_extender_pipe.md
Name: imm_extender_pipe

Overview:
Registered, parametrised successor to the combinational sign extender. It sits in the decode stage of the RV32I core and produces the XLEN-wide immediate for the U, I, J, S and B formats, plus the CSR zimm and shift-amount forms. It flags illegal format selects. The output is registered behind a valid/ready handshake with a 2-entry skid buffer, and a sideband tag (PC/rd bundle) travels alongside each immediate.

Parameters:
XLEN, 32, immediate output width; legal values are 32 and 64 (elaboration error otherwise)
TAG_W, 32, width of the sideband tag carried with each instruction

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
flush  input  1  discard all buffered entries (branch redirect)
in_valid  input  1  instruct/immSrc/in_tag are valid
in_ready  output  1  block can accept this cycle
instruct  input  32  raw instruction word
immSrc  input  3  format select (imm_src_t)
in_tag  input  TAG_W  sideband data
out_valid  output  1  extended/out_tag/out_err are valid
out_ready  input  1  consumer accepts this cycle
extended  output  XLEN  formatted immediate
out_tag  output  TAG_W  tag matching extended
out_err  output  1  immSrc was illegal for this entry

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous and active-high. While rst is high: out_valid=0, extended=0, out_tag=0, out_err=0, in_ready=0, skid buffer empty. in_ready=1 on the first cycle after rst deasserts.
- immSrc encoding: 0 U, 1 I, 2 J, 3 S, 4 B, 5 Z, 6 SH, 7 reserved.
- U: {instruct[31:12],12'b0}, sign-extended from bit 31 to XLEN.
- I: sext(instruct[31:20]).
- J: sext({instruct[31],instruct[19:12],instruct[20],instruct[30:21],1'b0}).
- S: sext({instruct[31:25],instruct[11:7]}).
- B: sext({instruct[31],instruct[7],instruct[30:25],instruct[11:8],1'b0}).
- Z: zero-extend instruct[19:15].
- SH: zero-extend instruct[24:20] when XLEN=32; zero-extend instruct[25:20] when XLEN=64.
- reserved (7): extended=0, out_err=1. All legal formats give out_err=0.
- Output storage: output register R0 drives the outputs; skid register R1 holds overflow. Both hold {extended, tag, err}.
- Accept condition: accept = in_valid & in_ready.
- in_ready = ~R1.valid & ~rst. This depends only on registered state; there is no combinational path from out_ready.
- Consume condition: consume = out_valid & out_ready.
- Per-cycle update, when flush is not asserted:
  - consume and R1 valid: R0 <= R1. If accept, R1 <= new entry, else R1 is cleared.
  - consume and R1 empty: R0 <= new entry if accept, else R0 is cleared.
  - no consume and R0 empty: R0 <= new entry if accept.
  - no consume and R0 full: R1 <= new entry if accept.
- Latency: 1 cycle from accept to out_valid when the buffer is empty. Throughput is 1 per cycle with out_ready held high.
- Ordering: strict FIFO; entries are never dropped or duplicated.
- Output stability: while out_valid=1 and out_ready=0, extended/out_tag/out_err stay stable.
- Flush: clears R0 and R1 on the next edge and overrides accept and consume in the same cycle. out_valid=0 on the following cycle and in_ready=1.
- Reset mid-operation: identical to flush, plus the output data registers are zeroed.
- Idle state: when out_valid=0, extended and out_tag hold their last value (don't-care to the consumer), except after reset, when they are 0.

Decomposition:
- Package imm_pkg:
  - typedef enum logic [2:0] imm_src_t {IMM_U, IMM_I, IMM_J, IMM_S, IMM_B, IMM_Z, IMM_SH, IMM_RSVD}
  - typedef for the buffered entry struct
- Sub-module imm_format: purely combinational instruct/immSrc -> extended/err, parametrised by XLEN. Instantiated once ahead of the skid logic and also unit-testable on its own.

Test Plan:
- Legal formats, XLEN=32, out_ready=1: the stream 0x003e80b7/U, 0x3e810093/I, 0x3e80006f/J, 0x3e112423/S, 0x00209663/B -> extended 4096000, 1000, 1000, 1000, 12 on consecutive cycles, each 1 cycle after accept, out_err=0.
- Sign, zero-extend and error forms:
  - 0xfff00093/I -> 0xFFFFFFFF (XLEN=64: 0xFFFFFFFF_FFFFFFFF).
  - 0xfe000ee3/B -> 0xFFFFFFFC.
  - instruct with [19:15]=5 under Z -> 5.
  - immSrc=7 -> extended 0, out_err=1.
- Backpressure: hold out_ready=0 and push tags 1, 2, 3 -> in_ready drops after 2 accepts. Raise out_ready -> tags 1, 2, 3 emerge in order, no loss, and outputs stay stable while stalled.
- Flush with R0 and R1 full, coincident with in_valid=1 -> next cycle out_valid=0, new entry not captured, in_ready=1.
- Reset mid-stream: assert rst for 1 cycle with 2 entries buffered -> all outputs 0 and in_ready=0 during rst, in_ready=1 after. Then a new 0x3e810093/I -> 1000.
- Random valid/ready toggling for 10k cycles against a scoreboard model -> exact in-order match, and in_ready never depends combinationally on out_ready.
